keypad_scanner: RTL and testbench

- Drives a 4x4 membrane keypad matrix: scans columns, synchronises and debounces rows, encodes one key per press.
- Produces the key-event interface consumed by the calculator control FSM: kbEN rising edge plus 4-bit pressedkey code.
- Sits between the board keypad pins and the calculator FSM.
- Exactly one kbEN pulse per physical press; no auto-repeat.

---
 rtl/calc_pkg.sv | 40 ++++
 rtl/keypad_debounce.sv | 55 +++++
 rtl/keypad_scanner.sv | 122 ++++++++++++
 tb/tb_keypad_scanner.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad scanner states and the
// row/column to key-code map used by the keypad scanner.
package calc_pkg;

    localparam logic [3:0] KEY_EQUAL = 4'd10;
    localparam logic [3:0] KEY_AC    = 4'd11;
    localparam logic [3:0] KEY_PLUS  = 4'd12;
    localparam logic [3:0] KEY_MINUS = 4'd13;
    localparam logic [3:0] KEY_MULT  = 4'd14;
    localparam logic [3:0] KEY_DIV   = 4'd15;

    typedef enum logic [2:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        STROBE,
        HOLD
    } scan_state_e;

    // Column 3 holds the operators, row 3 holds AC/0/equal, the rest are digits 1-9.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'd0;
        if (c == 2'd3) begin
            code = KEY_PLUS + {2'b00, r};
        end else if (r == 2'd3) begin
            if (c == 2'd0) begin
                code = KEY_AC;
            end else if (c == 2'd1) begin
                code = 4'd0;
            end else begin
                code = KEY_EQUAL;
            end
        end else begin
            code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Row synchroniser plus a stable-level counter; flags the cycle on which the
// selected row bit has matched the expected level for DEBOUNCE_CYCLES cycles.
module keypad_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    input  logic [1:0] sel,
    input  logic       level,
    input  logic       clear,
    output logic [3:0] rs,
    output logic       stable
);
    import calc_pkg::*;

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    meta_q, meta_d;
    logic [3:0]    rs_q, rs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          match;

    // The counter restarts on any mismatch and clears itself once it has fired.
    always_comb begin
        meta_d = row;
        rs_d   = meta_q;
        match  = (rs_q[sel] == level);
        stable = 1'b0;
        cnt_d  = '0;
        if (!clear && match) begin
            if (cnt_q == TERM) begin
                stable = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 4'hF;
            rs_q   <= 4'hF;
            cnt_q  <= '0;
        end else begin
            meta_q <= meta_d;
            rs_q   <= rs_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rs = rs_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates the column drive, debounces press and release,
// and emits one kbEN pulse per accepted key with pressedkey set up a cycle early.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       kbEN,
    output logic [3:0] pressedkey
);
    import calc_pkg::*;

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    scan_state_e   state_q, state_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    key_q, key_d;
    logic [3:0]    rs;
    logic          stable;
    logic          level;
    logic          clear;
    logic [1:0]    low_row;

    assign level = (state_q == HOLD);
    assign clear = !((state_q == DEBOUNCE) || (state_q == HOLD));

    keypad_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .row   (row),
        .sel   (row_idx_q),
        .level (level),
        .clear (clear),
        .rs    (rs),
        .stable(stable)
    );

    always_comb begin
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rs[i]) begin
                low_row = 2'(i);
            end
        end
    end

    // pressedkey is loaded on entry to EMIT so it leads the STROBE pulse by a cycle.
    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q;
        col_idx_d  = col_idx_q;
        row_idx_d  = row_idx_q;
        key_d      = key_q;
        case (state_q)
            SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (rs != 4'hF) begin
                        row_idx_d = low_row;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SW'(1);
                end
            end
            DEBOUNCE: begin
                if (rs[row_idx_q]) begin
                    state_d = SCAN;
                end else if (stable) begin
                    key_d   = key_code(row_idx_q, col_idx_q);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                state_d = STROBE;
            end
            STROBE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (stable) begin
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = SCAN;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SCAN;
            scan_cnt_q <= '0;
            col_idx_q  <= 2'd0;
            row_idx_q  <= 2'd0;
            key_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            col_idx_q  <= col_idx_d;
            row_idx_q  <= row_idx_d;
            key_q      <= key_d;
        end
    end

    assign col        = ~(4'b0001 << col_idx_q);
    assign kbEN       = (state_q == STROBE);
    assign pressedkey = key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad scanner bench: a matrix model drives the rows from the pressed keys and
// the driven column; key events are checked against the key table and timing bounds.
module tb_keypad_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int MAX_LAT  = 4 * SCAN_DIV + 2 + DEB + 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row;
    logic [3:0] col;
    logic       kbEN;
    logic [3:0] pressedkey;
    logic [15:0] keys = 16'h0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int ev_code[$];
    int ev_prev[$];
    int ev_cyc[$];
    int wide_cnt = 0;
    logic       kb_prev = 1'b0;
    logic [3:0] pk_prev = 4'd0;
    int key_map [16];

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .kbEN      (kbEN),
        .pressedkey(pressedkey)
    );

    always #5 clk = ~clk;

    // A row reads low when any pressed key on it sits in the column being driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (kbEN === 1'b1 && kb_prev !== 1'b1) begin
            ev_code.push_back(int'(pressedkey));
            ev_prev.push_back(int'(pk_prev));
            ev_cyc.push_back(cyc);
        end
        if (kbEN === 1'b1 && kb_prev === 1'b1) begin
            wide_cnt++;
        end
        kb_prev = kbEN;
        pk_prev = pressedkey;
    endtask

    task automatic applyStimulus(input logic [15:0] k, input int n);
        keys = k;
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearEvents();
        ev_code.delete();
        ev_prev.delete();
        ev_cyc.delete();
        wide_cnt = 0;
    endtask

    task automatic checkEvents(input string tag, input int exp, input int settle, input int eff_start);
        int code;
        int prev;
        int ev;
        code = (ev_code.size() > 0) ? ev_code[0] : -1;
        prev = (ev_prev.size() > 0) ? ev_prev[0] : -1;
        ev   = (ev_cyc.size() > 0) ? ev_cyc[0] : -1;
        checkOutput({tag, "_pulse_count"}, ev_code.size(), 1);
        checkOutput({tag, "_code"}, code, exp);
        checkOutput({tag, "_code_setup"}, prev, exp);
        checkOutput({tag, "_latency_max"}, int'((ev - settle) <= MAX_LAT), 1);
        checkOutput({tag, "_latency_min"}, int'((ev - eff_start) >= DEB + 2), 1);
        checkOutput({tag, "_pulse_width"}, wide_cnt, 0);
    endtask

    task automatic pressKey(input int r, input int c, input logic [7:0] pat, input int plen,
                            input int hold, input int gap, input string tag);
        logic [15:0] k;
        logic [3:0]  exp_col;
        int settle;
        int trail;
        k = 16'h0;
        k[r*4+c] = 1'b1;
        exp_col = 4'hF;
        exp_col[c] = 1'b0;
        clearEvents();
        trail = 0;
        for (int i = 0; i < plen; i++) begin
            applyStimulus(pat[i] ? k : 16'h0, 1);
            trail = pat[i] ? trail + 1 : 0;
        end
        settle = cyc;
        applyStimulus(k, hold);
        checkOutput({tag, "_col_frozen"}, int'(col), int'(exp_col));
        applyStimulus(16'h0, gap);
        checkEvents(tag, key_map[r*4+c], settle, settle - trail);
    endtask

    initial begin
        int n;
        int start;
        int sr [5];
        int sc [5];
        logic [15:0] k;
        logic [7:0] pat;
        key_map = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 11, 0, 10, 15};
        sr = '{0, 0, 0, 0, 3};
        sc = '{0, 1, 3, 2, 2};

        // Reset with all rows released, then free-running column rotation.
        reset = 1'b1;
        applyStimulus(16'h0, 3);
        checkOutput("reset_col", int'(col), 4'b1110);
        checkOutput("reset_kben", int'(kbEN), 0);
        checkOutput("reset_key", int'(pressedkey), 0);
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            logic [3:0] ec;
            tick();
            ec = 4'hF;
            ec[(i / SCAN_DIV) % 4] = 1'b0;
            checkOutput("rotate_col", int'(col), int'(ec));
        end

        // Key 5: single pulse, frozen column, release resumes at the next column.
        pressKey(1, 1, 8'h00, 0, 40, 0, "key5");
        n = 0;
        while (col == 4'b1101 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("key5_release_delay", int'(n >= DEB && n <= DEB + 3), 1);
        checkOutput("key5_resume_col", int'(col), 4'b1011);
        applyStimulus(16'h0, 4);

        // Equal with a 0,1,0 bounce while column 2 is being scanned.
        n = 0;
        while (col != 4'b1011 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("equal_reach_col2", int'(col), 4'b1011);
        pressKey(3, 2, 8'b0000_0101, 3, 40, 16, "equal");

        // Plus and mult together on column 3, then 7 pressed during HOLD.
        clearEvents();
        start = cyc;
        k = 16'h0;
        k[0*4+3] = 1'b1;
        k[2*4+3] = 1'b1;
        applyStimulus(k, 40);
        checkOutput("plus_mult_col", int'(col), 4'b0111);
        k[2*4+0] = 1'b1;
        applyStimulus(k, 30);
        applyStimulus(16'h0, 30);
        checkEvents("plus_mult", key_map[3], start, start);

        // Reset in the middle of debouncing key 9.
        n = 0;
        while (col == 4'b1011 && n < 40) begin
            tick();
            n++;
        end
        clearEvents();
        k = 16'h0;
        k[2*4+2] = 1'b1;
        keys = k;
        n = 0;
        while (col != 4'b1011 && n < 40) begin
            tick();
            n++;
        end
        checkOutput("key9_reach_col2", int'(col), 4'b1011);
        applyStimulus(k, 6);
        reset = 1'b1;
        applyStimulus(16'h0, 1);
        checkOutput("key9_reset_col", int'(col), 4'b1110);
        checkOutput("key9_reset_kben", int'(kbEN), 0);
        checkOutput("key9_reset_key", int'(pressedkey), 0);
        reset = 1'b0;
        applyStimulus(16'h0, 30);
        checkOutput("key9_no_pulse", ev_code.size(), 0);
        checkOutput("key9_key_zero", int'(pressedkey), 0);

        // Sequence 1, 2, plus, 3, equal.
        for (int i = 0; i < 5; i++) begin
            pressKey(sr[i], sc[i], 8'h00, 0, 40, 20, "sequence");
        end

        // Random keys, some with short bounce prefixes.
        for (int i = 0; i < 12; i++) begin
            int r;
            int c;
            int plen;
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            plen = (i % 3 == 0) ? int'($urandom_range(1, 6)) : 0;
            pat = 8'($urandom);
            pressKey(r, c, pat, plen, int'($urandom_range(32, 48)), int'($urandom_range(12, 24)), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
